// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg -- shared constants and types for the pixel frame buffer.
//   FB_W / FB_H   : buffer geometry in pixels (160x120)
//   COLOR_W       : bits per pixel, packed {r,g,b}
//   SCALE_SH      : log2 of screen-to-buffer scale (640x480 -> 160x120)
//   FB_DEPTH      : number of words in the buffer
//   FB_ADDR_W     : linear address width
//   fb_state_e    : write-side FSM states
// ---------------------------------------------------------------------------
package fb_pkg;

  localparam int FB_W      = 160;
  localparam int FB_H      = 120;
  localparam int COLOR_W   = 3;
  localparam int SCALE_SH  = 2;
  localparam int FB_DEPTH  = FB_W * FB_H;
  localparam int FB_ADDR_W = $clog2(FB_DEPTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_e;

  // Row-major linear address; evaluated at 32 bits so nothing is lost
  // before the caller narrows the result.
  function automatic int unsigned lin_addr(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned width);
    return row * width + col;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// ---------------------------------------------------------------------------
// fb_ram -- simple dual-port RAM, one write port and one registered read
// port, no reset, written to infer as block RAM.
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data, registered (one cycle after raddr_i)
// A read and write to the same address on the same edge returns old data.
// ---------------------------------------------------------------------------
module fb_ram #(
  parameter int DEPTH  = 19200,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/pixel_buffer.sv
// ---------------------------------------------------------------------------
// pixel_buffer -- 160x120 frame buffer scanned out at 640x480.
//   clk         in   pixel clock
//   reset       in   asynchronous active-low reset
//   vgaX/vgaY   in   current scan column/row from the timing generator
//   hsyncIn     in   active-low hsync from the timing generator
//   vsyncIn     in   active-low vsync from the timing generator
//   wrValid     in   pixel-write request
//   wrReady     out  write accepted when wrValid && wrReady
//   wrX/wrY     in   buffer column/row of the write
//   wrColor     in   pixel value to write
//   clearReq    in   one-cycle request to fill the buffer with clearColor
//   clearColor  in   fill value, captured when clearReq is taken
//   busy        out  high while a clear is running
//   hsync/vsync out  sync inputs delayed to line up with color
//   color       out  pixel color to the DAC, 2 cycles after vgaX/vgaY
// ---------------------------------------------------------------------------
module pixel_buffer #(
  parameter int FB_W     = fb_pkg::FB_W,
  parameter int FB_H     = fb_pkg::FB_H,
  parameter int SCALE_SH = fb_pkg::SCALE_SH,
  parameter int COLOR_W  = fb_pkg::COLOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         vgaX,
  input  logic [9:0]         vgaY,
  input  logic               hsyncIn,
  input  logic               vsyncIn,
  input  logic               wrValid,
  output logic               wrReady,
  input  logic [7:0]         wrX,
  input  logic [6:0]         wrY,
  input  logic [COLOR_W-1:0] wrColor,
  input  logic               clearReq,
  input  logic [COLOR_W-1:0] clearColor,
  output logic               busy,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] color
);

  import fb_pkg::*;

  localparam int DEPTH  = FB_W * FB_H;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int VIS_W  = FB_W << SCALE_SH;
  localparam int VIS_H  = FB_H << SCALE_SH;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // ---------------- write side ----------------
  fb_state_e           state_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   clr_addr_q;
  logic [COLOR_W-1:0]  clr_color_q;

  logic                wr_fire;
  logic                wr_in_range;
  logic [ADDR_W-1:0]   wr_addr;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [COLOR_W-1:0]  ram_wdata;

  // reset gates wrReady so nothing is acknowledged while held in reset.
  assign wrReady     = reset && (state_q == ST_IDLE) && !clearReq;
  assign wr_fire     = wrValid && wrReady;
  assign wr_in_range = (32'(wrX) < 32'(FB_W)) && (32'(wrY) < 32'(FB_H));
  assign wr_addr     = ADDR_W'(lin_addr(32'(wrY), 32'(wrX), FB_W));
  assign busy        = busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clearReq) begin
            state_q     <= ST_CLEAR;
            busy_q      <= 1'b1;
            clr_addr_q  <= '0;
            clr_color_q <= clearColor;
          end
        end
        ST_CLEAR: begin
          // clearReq is deliberately not looked at here.
          if (clr_addr_q == LAST_ADDR) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            clr_addr_q <= '0;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // The clear owns the write port; in IDLE only in-range accepted writes land.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wrColor;
    if (state_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_q;
      ram_wdata = clr_color_q;
    end else if (wr_fire && wr_in_range) begin
      ram_we = 1'b1;
    end
  end

  // ---------------- read side ----------------
  logic                vis_d;
  logic [ADDR_W-1:0]   rd_addr_d;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                vis1_q, vis2_q;
  logic                hs1_q, hs2_q;
  logic                vs1_q, vs2_q;
  logic [COLOR_W-1:0]  ram_rdata;

  assign vis_d = (32'(vgaX) < 32'(VIS_W)) && (32'(vgaY) < 32'(VIS_H));

  // Off-screen coordinates would map past the end of the buffer; park the
  // address at 0 since the output is blanked anyway.
  assign rd_addr_d = vis_d
                   ? ADDR_W'(lin_addr(32'(vgaY) >> SCALE_SH, 32'(vgaX) >> SCALE_SH, FB_W))
                   : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr_q <= '0;
      vis1_q    <= 1'b0;
      vis2_q    <= 1'b0;
      hs1_q     <= 1'b1;
      hs2_q     <= 1'b1;
      vs1_q     <= 1'b1;
      vs2_q     <= 1'b1;
    end else begin
      rd_addr_q <= rd_addr_d;
      vis1_q    <= vis_d;
      vis2_q    <= vis1_q;
      hs1_q     <= hsyncIn;
      hs2_q     <= hs1_q;
      vs1_q     <= vsyncIn;
      vs2_q     <= vs1_q;
    end
  end

  fb_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (COLOR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (rd_addr_q),
    .rdata_o (ram_rdata)
  );

  // RAM output is unreset, so blanking via the reset-cleared flag also
  // forces color to 0 during reset.
  assign color = vis2_q ? ram_rdata : '0;
  assign hsync = hs2_q;
  assign vsync = vs2_q;

endmodule

// File: tb/tb_pixel_buffer.sv
module tb_pixel_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] vgaX = '0;
  logic [9:0] vgaY = '0;
  logic       hsyncIn = 1'b1;
  logic       vsyncIn = 1'b1;
  logic       wrValid = 1'b0;
  logic       wrReady;
  logic [7:0] wrX = '0;
  logic [6:0] wrY = '0;
  logic [2:0] wrColor = '0;
  logic       clearReq = 1'b0;
  logic [2:0] clearColor = '0;
  logic       busy;
  logic       hsync;
  logic       vsync;
  logic [2:0] color;

  pixel_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .vgaX       (vgaX),
    .vgaY       (vgaY),
    .hsyncIn    (hsyncIn),
    .vsyncIn    (vsyncIn),
    .wrValid    (wrValid),
    .wrReady    (wrReady),
    .wrX        (wrX),
    .wrY        (wrY),
    .wrColor    (wrColor),
    .clearReq   (clearReq),
    .clearColor (clearColor),
    .busy       (busy),
    .hsync      (hsync),
    .vsync      (vsync),
    .color      (color)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int unsigned at;
    logic [2:0]  color;
    logic        hs;
    logic        vs;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Monitor: compares the pixel output against whatever the stimulus queued
  // for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at < cyc) begin
      mon_e = sb.pop_front();
      chk({mon_e.name, "_missed"}, 32'd1, 32'd0);
    end
    if (sb.size() > 0 && sb[0].at == cyc) begin
      mon_e = sb.pop_front();
      chk({mon_e.name, "_color"}, 32'(color), 32'(mon_e.color));
      chk({mon_e.name, "_sync"}, 32'({hsync, vsync}), 32'({mon_e.hs, mon_e.vs}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a scan coordinate this cycle; its color/sync appear 2 cycles on.
  task automatic drive_pix(input int x, input int y, input logic hs, input logic vs,
                           input logic [2:0] ec, input string name);
    exp_t e;
    vgaX    = 10'(x);
    vgaY    = 10'(y);
    hsyncIn = hs;
    vsyncIn = vs;
    e.at    = cyc + 2;
    e.color = ec;
    e.hs    = hs;
    e.vs    = vs;
    e.name  = name;
    sb.push_back(e);
    tick();
  endtask

  task automatic write_px(input int x, input int y, input logic [2:0] c);
    wrX     = 8'(x);
    wrY     = 7'(y);
    wrColor = c;
    wrValid = 1'b1;
    #1;
    chk($sformatf("wr_ready_%0d_%0d", x, y), 32'(wrReady), 32'd1);
    tick();
    wrValid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;

    // ---- reset state ----
    wrValid = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_color", 32'(color), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_wrready", 32'(wrReady), 32'd0);
    wrValid = 1'b0;
    reset = 1'b1;
    tick();
    chk("idle_wrready", 32'(wrReady), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // ---- basic writes and 2-cycle read ----
    write_px(5, 3, 3'b101);
    write_px(6, 3, 3'b000);
    write_px(4, 3, 3'b000);
    write_px(0, 1, 3'b110);
    write_px(159, 119, 3'b111);
    for (int y = 12; y <= 15; y++)
      for (int x = 20; x <= 24; x++)
        drive_pix(x, y, logic'(x % 2), logic'(y % 2), (x < 24) ? 3'b101 : 3'b000,
                  $sformatf("rd_%0d_%0d", x, y));

    // ---- visibility boundaries and sync delay ----
    drive_pix(650, 12, 1'b1, 1'b1, 3'b000, "offx_650");
    drive_pix(20, 500, 1'b1, 1'b1, 3'b000, "offy_500");
    drive_pix(640, 476, 1'b1, 1'b1, 3'b000, "offx_640");
    drive_pix(639, 479, 1'b1, 1'b1, 3'b111, "corner");
    drive_pix(636, 480, 1'b1, 1'b1, 3'b000, "offy_480");
    drive_pix(0, 4, 1'b1, 1'b1, 3'b110, "px_0_1");
    drive_pix(800, 0, 1'b0, 1'b1, 3'b000, "sync_a");
    drive_pix(800, 0, 1'b1, 1'b0, 3'b000, "sync_b");
    drive_pix(800, 0, 1'b0, 1'b0, 3'b000, "sync_c");
    drive_pix(800, 0, 1'b1, 1'b1, 3'b000, "sync_d");

    // ---- out-of-range writes acknowledged and dropped ----
    write_px(160, 0, 3'b001);
    write_px(0, 120, 3'b001);
    drive_pix(0, 4, 1'b1, 1'b1, 3'b110, "oor_px_0_1");

    // ---- same-cycle read/write returns old data ----
    drive_pix(20, 12, 1'b1, 1'b1, 3'b101, "rw_old");
    wrX = 8'd5; wrY = 7'd3; wrColor = 3'b100; wrValid = 1'b1;
    drive_pix(20, 12, 1'b1, 1'b1, 3'b100, "rw_new");
    wrValid = 1'b0;
    drive_pix(24, 12, 1'b1, 1'b1, 3'b000, "rw_neigh");

    // ---- clear wins over a same-cycle write ----
    wrX = 8'd5; wrY = 7'd3; wrColor = 3'b111; wrValid = 1'b1;
    clearReq = 1'b1; clearColor = 3'b010;
    #1;
    chk("collide_wrready", 32'(wrReady), 32'd0);
    tick();
    clearReq = 1'b0; wrValid = 1'b0; clearColor = 3'b101;
    n = 0; bad = 0;
    while (busy === 1'b1 && n < 25000) begin
      if (wrReady !== 1'b0) bad++;
      if (n == 5000) clearReq = 1'b1;   // must be ignored mid-clear
      if (n == 5001) clearReq = 1'b0;
      n++;
      tick();
    end
    chk("clear_cycles", 32'(n), 32'd19200);
    chk("clear_wrready_low", 32'(bad), 32'd0);
    chk("post_clear_wrready", 32'(wrReady), 32'd1);

    // ---- every buffer pixel now holds the fill ----
    for (int r = 0; r < 120; r++)
      for (int c = 0; c < 160; c++)
        drive_pix(c * 4 + (c % 4), r * 4 + (r % 4), 1'b1, 1'b1, 3'b010,
                  $sformatf("fill_%0d_%0d", c, r));

    // ---- reset during a clear ----
    vgaX = 10'd400; vgaY = 10'd400; hsyncIn = 1'b0; vsyncIn = 1'b0;
    clearReq = 1'b1; clearColor = 3'b001;
    tick();
    clearReq = 1'b0;
    repeat (100) tick();
    chk("pre_abort_color", 32'(color), 32'd2);
    chk("pre_abort_hsync", 32'(hsync), 32'd0);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_color", 32'(color), 32'd0);
    chk("abort_hsync", 32'(hsync), 32'd1);
    chk("abort_vsync", 32'(vsync), 32'd1);
    chk("abort_wrready", 32'(wrReady), 32'd0);
    hsyncIn = 1'b1; vsyncIn = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("after_abort_wrready", 32'(wrReady), 32'd1);
    chk("after_abort_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 100; c++)
      drive_pix(c * 4, 0, 1'b1, 1'b1, 3'b001, $sformatf("abort_fill_%0d", c));
    drive_pix(400, 0, 1'b1, 1'b1, 3'b010, "abort_unfilled_100");
    drive_pix(0, 4, 1'b1, 1'b1, 3'b010, "abort_unfilled_160");

    repeat (4) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
